lc_ext_state_checker: RTL and testbench

- Receiving end of the replicated decoded life-cycle state bus (`ext_dec_lc_state_t`, i.e. `DecLcStateNumRep` copies of `dec_lc_state_e`).
- Accepts words via a valid/ready handshake and checks that all replicas agree and encode a legal state.
- Enforces monotonic forward state progression.
- Publishes one registered decoded state; escalates after repeated faults.
- Sits between the life-cycle state producer and downstream consumers (alert/escalation logic).

---
 rtl/lc_dec_pkg.sv | 50 +++++
 rtl/lc_rep_compare.sv | 23 ++
 rtl/lc_ext_state_checker.sv | 104 ++++++++++
 tb/tb_lc_ext_state_checker.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/lc_dec_pkg.sv
// Shared life-cycle decode types: replica geometry, decoded state encoding and
// the checker FSM states.
package lc_dec_pkg;

  function automatic int unsigned vbits(input int unsigned value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

  localparam int unsigned NumLcStates        = 21;
  localparam int unsigned DecLcStateWidth    = vbits(NumLcStates);
  localparam int unsigned DecLcStateNumRep   = 32 / DecLcStateWidth;
  localparam int unsigned ExtDecLcStateWidth = DecLcStateNumRep * DecLcStateWidth;

  typedef enum logic [DecLcStateWidth-1:0] {
    DecLcStRaw           = 5'd0,
    DecLcStTestUnlocked0 = 5'd1,
    DecLcStTestLocked0   = 5'd2,
    DecLcStTestUnlocked1 = 5'd3,
    DecLcStTestLocked1   = 5'd4,
    DecLcStTestUnlocked2 = 5'd5,
    DecLcStTestLocked2   = 5'd6,
    DecLcStTestUnlocked3 = 5'd7,
    DecLcStTestLocked3   = 5'd8,
    DecLcStTestUnlocked4 = 5'd9,
    DecLcStTestLocked4   = 5'd10,
    DecLcStTestUnlocked5 = 5'd11,
    DecLcStTestLocked5   = 5'd12,
    DecLcStTestUnlocked6 = 5'd13,
    DecLcStTestLocked6   = 5'd14,
    DecLcStTestUnlocked7 = 5'd15,
    DecLcStDev           = 5'd16,
    DecLcStProd          = 5'd17,
    DecLcStProdEnd       = 5'd18,
    DecLcStRma           = 5'd19,
    DecLcStScrap         = 5'd20,
    DecLcStPostTrans     = 5'd21,
    DecLcStEscalate      = 5'd22,
    DecLcStInvalid       = 5'd23
  } dec_lc_state_e;

  typedef dec_lc_state_e [DecLcStateNumRep-1:0] ext_dec_lc_state_t;

  typedef enum logic [1:0] {
    StReset,
    StIdle,
    StTrack,
    StEsc
  } ext_chk_state_e;

endpackage

// File: rtl/lc_rep_compare.sv
// Unpacks the replicated state bus, reports whether all replicas agree and
// whether replica 0 lies outside the defined encoding.
module lc_rep_compare
  import lc_dec_pkg::*;
(
  input  logic [ExtDecLcStateWidth-1:0] ext_state_i,
  output logic                          all_equal,
  output logic [DecLcStateWidth-1:0]    rep0,
  output logic                          illegal
);

  always_comb begin
    rep0      = ext_state_i[DecLcStateWidth-1:0];
    all_equal = 1'b1;
    for (int unsigned k = 1; k < DecLcStateNumRep; k++) begin
      if (ext_state_i[k*DecLcStateWidth +: DecLcStateWidth] != rep0) begin
        all_equal = 1'b0;
      end
    end
    illegal = (rep0 > DecLcStInvalid);
  end

endmodule

// File: rtl/lc_ext_state_checker.sv
// Accepts replicated life-cycle state words, rejects inconsistent, illegal or
// backward words, and escalates permanently after repeated consecutive faults.
module lc_ext_state_checker
  import lc_dec_pkg::*;
#(
  parameter int unsigned EscThreshold = 3
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [ExtDecLcStateWidth-1:0] ext_state_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic [DecLcStateWidth-1:0]    state_o,
  output logic                          state_valid_o,
  output logic                          mismatch_o,
  output logic                          invalid_o,
  output logic                          backward_o,
  output logic [3:0]                    err_cnt_o,
  output logic                          escalate_o
);

  ext_chk_state_e             fsmState;
  logic                       allEqual;
  logic                       illegal;
  logic [DecLcStateWidth-1:0] rep0;
  logic                       accept;
  logic                       isMismatch;
  logic                       isInvalid;
  logic                       isBackward;
  logic                       isFault;
  logic [3:0]                 errNext;
  logic                       escNow;

  lc_rep_compare uRepCompare (
    .ext_state_i (ext_state_i),
    .all_equal   (allEqual),
    .rep0        (rep0),
    .illegal     (illegal)
  );

  // Fault classes are mutually exclusive so only the highest priority pulses.
  always_comb begin
    accept     = valid_i && ready_o;
    isMismatch = !allEqual;
    isInvalid  = allEqual && illegal;
    isBackward = allEqual && !illegal && (fsmState == StTrack) && (rep0 < state_o);
    isFault    = isMismatch || isInvalid || isBackward;
    errNext    = (err_cnt_o == 4'hF) ? 4'hF : err_cnt_o + 4'd1;
    escNow     = (32'(errNext) >= EscThreshold);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fsmState      <= StReset;
      ready_o       <= 1'b0;
      state_o       <= DecLcStInvalid;
      state_valid_o <= 1'b0;
      mismatch_o    <= 1'b0;
      invalid_o     <= 1'b0;
      backward_o    <= 1'b0;
      err_cnt_o     <= '0;
      escalate_o    <= 1'b0;
    end else begin
      mismatch_o <= 1'b0;
      invalid_o  <= 1'b0;
      backward_o <= 1'b0;
      case (fsmState)
        StReset: begin
          fsmState <= StIdle;
          ready_o  <= 1'b1;
        end
        StIdle, StTrack: begin
          if (accept) begin
            if (isFault) begin
              mismatch_o <= isMismatch;
              invalid_o  <= isInvalid;
              backward_o <= isBackward;
              err_cnt_o  <= errNext;
              if (escNow) begin
                fsmState      <= StEsc;
                ready_o       <= 1'b0;
                escalate_o    <= 1'b1;
                state_o       <= DecLcStEscalate;
                state_valid_o <= 1'b1;
              end
            end else begin
              fsmState      <= StTrack;
              state_o       <= rep0;
              state_valid_o <= 1'b1;
              err_cnt_o     <= '0;
            end
          end
        end
        StEsc: begin
          fsmState <= StEsc;
        end
        default: begin
          fsmState <= StEsc;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lc_ext_state_checker.sv
// Directed bench for lc_ext_state_checker with hand-computed expectations.
module tb_lc_ext_state_checker;

  logic        clk;
  logic        rst;
  logic [29:0] extState;
  logic        validIn;
  logic        ready;
  logic [4:0]  state;
  logic        stateValid;
  logic        mismatch;
  logic        invalid;
  logic        backward;
  logic [3:0]  errCnt;
  logic        escalate;

  int testCount;
  int failCount;

  lc_ext_state_checker #(.EscThreshold(3)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .ext_state_i   (extState),
    .valid_i       (validIn),
    .ready_o       (ready),
    .state_o       (state),
    .state_valid_o (stateValid),
    .mismatch_o    (mismatch),
    .invalid_o     (invalid),
    .backward_o    (backward),
    .err_cnt_o     (errCnt),
    .escalate_o    (escalate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic checkOutputs(input string tag, input int st, input int sv, input int mm,
                              input int inv, input int bk, input int err, input int esc,
                              input int rdy);
    checkEq({tag, "/state"},      32'(state),      32'(st));
    checkEq({tag, "/stateValid"}, 32'(stateValid), 32'(sv));
    checkEq({tag, "/mismatch"},   32'(mismatch),   32'(mm));
    checkEq({tag, "/invalid"},    32'(invalid),    32'(inv));
    checkEq({tag, "/backward"},   32'(backward),   32'(bk));
    checkEq({tag, "/errCnt"},     32'(errCnt),     32'(err));
    checkEq({tag, "/escalate"},   32'(escalate),   32'(esc));
    checkEq({tag, "/ready"},      32'(ready),      32'(rdy));
  endtask

  function automatic logic [29:0] rep6(input logic [4:0] v);
    return {6{v}};
  endfunction

  task automatic sendWord(input logic [29:0] w);
    @(negedge clk);
    extState = w;
    validIn  = 1'b1;
    @(posedge clk);
    #1;
    validIn = 1'b0;
  endtask

  task automatic idleCycle();
    @(posedge clk);
    #1;
  endtask

  logic [29:0] word;

  initial begin
    testCount = 0;
    failCount = 0;
    rst       = 1'b1;
    validIn   = 1'b0;
    extState  = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutputs("reset", 23, 0, 0, 0, 0, 0, 0, 0);

    @(negedge clk);
    rst = 1'b0;
    #1;
    checkEq("releaseReady0", 32'(ready), 32'd0);
    idleCycle();
    checkOutputs("idle", 23, 0, 0, 0, 0, 0, 0, 1);

    sendWord(rep6(5'd16));
    checkOutputs("dev", 16, 1, 0, 0, 0, 0, 0, 1);
    sendWord(rep6(5'd17));
    checkOutputs("prod", 17, 1, 0, 0, 0, 0, 0, 1);

    word = rep6(5'd17);
    word[19:15] = 5'd18;
    sendWord(word);
    checkOutputs("mismatch", 17, 1, 1, 0, 0, 1, 0, 1);
    idleCycle();
    checkOutputs("mismatchClr", 17, 1, 0, 0, 0, 1, 0, 1);

    sendWord(rep6(5'd25));
    checkOutputs("invalid", 17, 1, 0, 1, 0, 2, 0, 1);

    sendWord(rep6(5'd10));
    checkOutputs("backwardEsc", 22, 1, 0, 0, 1, 3, 1, 0);

    sendWord(rep6(5'd19));
    checkOutputs("escHold", 22, 1, 0, 0, 0, 3, 1, 0);
    sendWord(rep6(5'd3));
    checkOutputs("escHold2", 22, 1, 0, 0, 0, 3, 1, 0);

    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutputs("asyncReset", 23, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkEq("release2Ready0", 32'(ready), 32'd0);
    idleCycle();
    checkEq("release2Ready1", 32'(ready), 32'd1);

    sendWord(rep6(5'd0));
    checkOutputs("raw", 0, 1, 0, 0, 0, 0, 0, 1);

    word = rep6(5'd18);
    word[4:0] = 5'd2;
    sendWord(word);
    checkOutputs("fault", 0, 1, 1, 0, 0, 1, 0, 1);
    sendWord(rep6(5'd18));
    checkOutputs("recover", 18, 1, 0, 0, 0, 0, 0, 1);
    sendWord(rep6(5'd18));
    checkOutputs("resend", 18, 1, 0, 0, 0, 0, 0, 1);

    sendWord(rep6(5'd24));
    checkOutputs("invalid24", 18, 1, 0, 1, 0, 1, 0, 1);
    sendWord(rep6(5'd23));
    checkOutputs("legal23", 23, 1, 0, 0, 0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
